ps2_host_tx: RTL and testbench

//   Host-to-device PS/2 transmitter; the send side of the existing ps2_keyboard receiver.

---
 rtl/ps2_host_tx.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Sends one byte to the device. It inhibits the clock, issues a request-to-send,
// then shifts the bits out on device clock falling edges, and finally checks the ACK.
// Both pads are open-drain. The *_oe outputs pull the line low when they are 1.
// Optional feature macro: PS2_TX_RETRY_EN. When it is defined, a failed attempt is
// retried up to twice with the same byte before tx_err is pulsed.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int unsigned WDT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_WAIT_IDLE,
    S_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [2:0]       data_sync_q, data_sync_d;
  logic             clk_prev_q, clk_prev_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  // Synchronised line levels. The falling edge compares the last two synced samples.
  logic clk_s, data_s, clk_fe;
  assign clk_s  = clk_sync_q[2];
  assign data_s = data_sync_q[2];
  assign clk_fe = clk_prev_q & ~clk_s;

  // Next-state logic: FSM transitions, bit serialisation, inhibit timer and watchdog.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one unassigned (no latch).
    state_d     = state_q;
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk_i};
    data_sync_d = {data_sync_q[1:0], ps2_data_i};
    clk_prev_d  = clk_s;
    inh_cnt_d   = inh_cnt_q;
    wdt_d       = wdt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    data_oe_d   = data_oe_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d     = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d   = tx_data;
          par_d     = ~^tx_data;
          inh_cnt_d = '0;
          state_d   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d   = '0;
`endif
        end
      end

      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          // Release the clock and present the start bit in the same cycle.
          data_oe_d = 1'b1;
          bit_cnt_d = '0;
          wdt_d     = '0;
          state_d   = S_RTS;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end

      S_RTS: begin
        if (clk_fe) begin
          wdt_d     = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            data_oe_d = ~shift_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            data_oe_d = ~par_q;
          end else if (bit_cnt_q == 4'd9) begin
            data_oe_d = 1'b0;
          end else begin
            // The 11th edge carries the device ACK: a low data line means success.
            data_oe_d = 1'b0;
            state_d   = data_s ? S_FAIL : S_WAIT_IDLE;
          end
        end else if (wdt_q == WDT_LAST) begin
          data_oe_d = 1'b0;
          state_d   = S_FAIL;
        end else begin
          wdt_d = wdt_q + WDT_W'(1);
        end
      end

      S_WAIT_IDLE: begin
        data_oe_d = 1'b0;
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (clk_fe) begin
          wdt_d = '0;
        end else if (wdt_q == WDT_LAST) begin
          state_d = S_FAIL;
        end else begin
          wdt_d = wdt_q + WDT_W'(1);
        end
      end

      S_FAIL: begin
        data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
        if (retry_q < 2'd2) begin
          retry_d   = retry_q + 2'd1;
          inh_cnt_d = '0;
          state_d   = S_INHIBIT;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
`else
        err_d   = 1'b1;
        state_d = S_IDLE;
`endif
      end

      default: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State register. Lines idle high, so the synchronisers reset to 1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      state_q     <= S_IDLE;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      inh_cnt_q   <= '0;
      wdt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      inh_cnt_q   <= inh_cnt_d;
      wdt_q       <= wdt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      data_oe_q   <= data_oe_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef PS2_TX_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign tx_busy     = (state_q != S_IDLE);
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = (state_q == S_INHIBIT);
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with a behavioural PS/2 device.
// The device model clocks the bus and records the bits it sees on the wire. The bench
// compares them with the byte sent, odd parity and the expected ACK or timeout outcome.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int TMO  = 200;
  localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_i, ps2_data_i;

  int compared   = 0;
  int mismatched = 0;
  int n_done     = 0;
  int n_err      = 0;

  // Open-drain wired-AND of host and device.
  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic model_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  // Count result pulses every cycle. A 2-cycle pulse shows up as a count of 2.
  always @(negedge clk) begin
    if (tx_done) n_done++;
    if (tx_err) n_err++;
    if (tx_done || tx_err) check("done_err_excl", {31'd0, tx_done & tx_err}, 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic send(input logic [7:0] d);
    int g = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && g < 4 * TMO * ATTEMPTS) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    check("accept_ready_drop", tx_ready, 0);
  endtask

  // Device side of one attempt. It measures the inhibit, clocks n_fe falling edges and
  // samples the wire in each low phase. It can also assert reset at edge abort_fe.
  task automatic dev_xfer(input int n_fe, input bit ack, input int abort_fe,
                          output logic [7:0] bits, output logic par, output logic stop);
    int g;
    int len;
    logic prev, s1, s2;
    bits = '0;
    par  = 1'b0;
    stop = 1'b0;
    prev = 1'b0;
    g = 0;
    while (!ps2_clk_oe && g < 4 * TMO) begin
      @(negedge clk);
      g++;
    end
    check("inhibit_seen", ps2_clk_oe, 1);
    if (!ps2_clk_oe) return;
    len = 0;
    while (ps2_clk_oe && len < 4 * INH) begin
      len++;
      @(negedge clk);
    end
    check("inhibit_len", len, INH);
    check("start_bit_oe", ps2_data_oe, 1);
    for (int i = 1; i <= n_fe; i++) begin
      repeat (HALF / 2) @(negedge clk);
      check("hold_high", ps2_data_i, prev);
      if (i == 11 && ack) dev_data = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      dev_clk = 1'b0;
      if (i == abort_fe) begin
        resetn = 1'b0;
        #1;
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_err, 0);
        dev_clk = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        return;
      end
      repeat (8) @(negedge clk);
      s1 = ps2_data_i;
      repeat (HALF - 8) @(negedge clk);
      s2 = ps2_data_i;
      if (i <= 10) check("hold_low", s2, s1);
      dev_clk = 1'b1;
      if (i <= 8) bits[i-1] = s1;
      else if (i == 9) par = s1;
      else if (i == 10) stop = s1;
      prev = s1;
    end
    if (n_fe == 11) begin
      repeat (5) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!tx_ready && cyc < 6 * TMO * ATTEMPTS) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_return", tx_ready, 1);
  endtask

  // mode 0: device ACKs; mode 1: no ACK at edge 11; mode 2: device stops after edge 4.
  task automatic run_xfer(input logic [7:0] d, input int mode);
    int d0, e0, cyc, n_att;
    logic [7:0] bits;
    logic par, stop;
    d0 = n_done;
    e0 = n_err;
    send(d);
    n_att = (mode == 0) ? 1 : ATTEMPTS;
    for (int a = 0; a < n_att; a++) begin
      dev_xfer((mode == 2) ? 4 : 11, mode == 0, 0, bits, par, stop);
      if (mode == 2) begin
        check("partial_bits", {28'd0, bits[3:0]}, {28'd0, d[3:0]});
      end else begin
        check("data_bits", bits, d);
        check("parity", par, model_par(d));
        check("stop_bit", stop, 1);
      end
    end
    wait_ready(cyc);
    if (mode == 2) check("timeout_latency", (cyc >= TMO - HALF && cyc <= TMO - HALF + 8), 1);
    @(negedge clk);
    #1;
    check("done_count", n_done - d0, (mode == 0) ? 1 : 0);
    check("err_count", n_err - e0, (mode != 0) ? 1 : 0);
    check("clk_oe_idle", ps2_clk_oe, 0);
    check("data_oe_idle", ps2_data_oe, 0);
    check("ready_idle", tx_ready, 1);
  endtask

  initial begin
    logic [7:0] bits, rnd;
    logic par, stop;
    int d0, e0, cyc, m;

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", tx_ready, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_done", tx_done, 0);
    check("reset_err", tx_err, 0);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_data_oe", ps2_data_oe, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    run_xfer(8'hED, 0);
    run_xfer(8'h01, 0);
    run_xfer(8'hFF, 1);
    run_xfer(8'hF4, 2);

    // Reset at the 6th falling edge aborts silently; the next send must still work.
    d0 = n_done;
    e0 = n_err;
    send(8'hED);
    dev_xfer(11, 1'b1, 6, bits, par, stop);
    repeat (5) @(negedge clk);
    #1;
    check("abort_done", n_done - d0, 0);
    check("abort_err", n_err - e0, 0);
    check("abort_ready", tx_ready, 1);
    run_xfer(8'hED, 0);

    // tx_valid held with a new byte during a transfer: it is taken only once the bus is idle again.
    d0 = n_done;
    send(8'hED);
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    dev_xfer(11, 1'b1, 0, bits, par, stop);
    check("held_bits", bits, 8'hED);
    check("held_stop", stop, 1);
    wait_ready(cyc);
    @(negedge clk);
    check("late_accept", tx_ready, 0);
    tx_valid = 1'b0;
    dev_xfer(11, 1'b1, 0, bits, par, stop);
    check("queued_bits", bits, 8'hAA);
    check("queued_par", par, model_par(8'hAA));
    wait_ready(cyc);
    @(negedge clk);
    #1;
    check("queued_done_count", n_done - d0, 2);

    for (int k = 0; k < 8; k++) begin
      rnd = 8'($urandom);
      m   = int'($urandom_range(0, 2));
      run_xfer(rnd, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
